div_unit: RTL
=============

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset, with the ports named clk and reset.
REQ-002 Port clk SHALL be: input, 1 bit, rising-edge clock for all state.
REQ-003 Port reset SHALL be: input, 1 bit, asynchronous active-high reset.
REQ-004 Port start SHALL be: input, 1 bit, request to begin a divide; sampled only in IDLE.
REQ-005 Port a_in SHALL be: input, 32 bits, signed dividend (two's complement).
REQ-006 Port b_in SHALL be: input, 32 bits, signed divisor (two's complement).
REQ-007 Port hi SHALL be: output, 32 bits, registered remainder, feeding the Hi register mux.
REQ-008 Port lo SHALL be: output, 32 bits, registered quotient, feeding the Lo register mux.
REQ-009 Port busy SHALL be: output, 1 bit, high whenever the state is not IDLE.
REQ-010 Port done SHALL be: output, 1 bit, one-cycle pulse marking that a result or exception is available.
REQ-011 Port div_zero SHALL be: output, 1 bit, one-cycle pulse coincident with done when the divisor was zero.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN and DONE, all registered.
REQ-013 In IDLE, start=1 at edge E0 with b_in!=0 SHALL latch |a_in|, |b_in|, sign(a_in) and sign(a_in)^sign(b_in), clear the 33-bit partial remainder, load a 6-bit step counter with 0, and enter RUN.
REQ-014 In IDLE, start=1 at edge E0 with b_in==0 SHALL enter DONE directly with div_zero set, leaving hi and lo unchanged.
REQ-015 In RUN, each edge SHALL perform one restoring step: shift {remainder, quotient} left 1; subtract the divisor magnitude; if the result is non-negative keep it and set the quotient LSB to 1, otherwise restore and set it to 0.
REQ-016 RUN SHALL last exactly 32 edges (E1..E32), after which the counter reaches 32.
REQ-017 At edge E33, the block SHALL write lo = quotient negated if the quotient sign is 1, SHALL write hi = remainder negated if the dividend sign is 1, and SHALL enter DONE.
REQ-018 Rounding SHALL truncate toward zero, and the remainder sign SHALL follow the dividend (MIPS DIV semantics).
REQ-019 Results SHALL be truncated to 32 bits; 0x80000000 / 0xFFFFFFFF SHALL yield lo=0x80000000 and hi=0, with no flag raised.
REQ-020 done SHALL be 1 only during DONE; DONE SHALL last exactly one cycle, then return to IDLE.
REQ-021 Normal latency SHALL be: done is high in the cycle following E33, i.e. 33 edges after the start sample.
REQ-022 Divide-by-zero latency SHALL be: done and div_zero are high in the cycle following E0.
REQ-023 start SHALL be ignored in RUN and DONE; no queuing is performed.
REQ-024 Operands SHALL be captured only at E0; changes to a_in or b_in during RUN SHALL have no effect.
REQ-025 hi and lo SHALL hold their last written values until the next successful completion; they SHALL NOT change during RUN.
REQ-026 busy SHALL equal 1 in RUN and DONE and 0 in IDLE.

Reset
REQ-027 Asserting reset at any time, including mid-RUN, SHALL immediately force: state to IDLE, hi to 0, lo to 0, counter to 0, busy to 0, done to 0 and div_zero to 0.
REQ-028 An operation interrupted by reset SHALL produce no done pulse; the first edge after reset release SHALL be able to accept start.

Verification
REQ-029 Positive divide: a=100, b=7 with start at E0 -> busy=1 for 34 cycles; done=1 in the cycle after E33; lo=14, hi=2.
REQ-030 Negative dividend: a=-100 (0xFFFFFF9C), b=7 -> lo=0xFFFFFFF2 (-14), hi=0xFFFFFFFE (-2); div_zero=0.
REQ-031 Divide by zero: following a completed 100/7, issue a=7, b=0 -> done=1 and div_zero=1 in the cycle after E0; hi=2 and lo=14 are retained.
REQ-032 Overflow corner: a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0, same latency as REQ-029.
REQ-033 Reset mid-RUN: start 100/7, assert reset at E10 -> hi=lo=0 and busy=0 immediately; no done pulse; a new start at the first edge after release completes normally.
REQ-034 Start while busy: start pulses at E5 and E20 during an 81/9 operation -> exactly one done; lo=9, hi=0.

Source files
------------

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module   : div_unit
// Purpose  : 32-bit signed integer divider (MIPS DIV semantics). Restoring
//            division on operand magnitudes, one quotient bit per clock,
//            signs applied on write-back. The quotient truncates toward
//            zero and the remainder takes the sign of the dividend.
// Ports    : clk      - rising-edge clock for all state
//            reset    - asynchronous active-high reset
//            start    - begin a divide (sampled only in IDLE)
//            a_in     - signed dividend
//            b_in     - signed divisor
//            hi       - registered remainder
//            lo       - registered quotient
//            busy     - high whenever the FSM is not IDLE
//            done     - one-cycle pulse: result or exception available
//            div_zero - one-cycle pulse with done when the divisor was zero
// Revision : 1.0 - initial release
// ============================================================================
module div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);

  localparam logic [5:0] C_STEPS = 6'd32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [32:0] r_rem;     // partial remainder
  logic [31:0] r_quo;     // dividend magnitude shifting out, quotient in
  logic [31:0] r_dvsr;    // divisor magnitude
  logic [5:0]  r_cnt;
  logic        r_q_sign;
  logic        r_r_sign;

  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [33:0] w_shift;
  logic [33:0] w_diff;

  // Magnitudes are taken as unsigned 32-bit values, so |0x80000000| is
  // represented exactly as 0x80000000.
  assign w_abs_a = a_in[31] ? (32'd0 - a_in) : a_in;
  assign w_abs_b = b_in[31] ? (32'd0 - b_in) : b_in;

  // One restoring step: shift the next dividend bit into the remainder and
  // trial-subtract the divisor; the MSB of the difference is its sign.
  assign w_shift = {r_rem, r_quo[31]};
  assign w_diff  = w_shift - {2'b00, r_dvsr};

  assign busy = (r_state != S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_rem    <= 33'd0;
      r_quo    <= 32'd0;
      r_dvsr   <= 32'd0;
      r_cnt    <= 6'd0;
      r_q_sign <= 1'b0;
      r_r_sign <= 1'b0;
      hi       <= 32'd0;
      lo       <= 32'd0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (b_in == 32'd0) begin
              // Exception path: hi/lo keep their previous contents.
              done     <= 1'b1;
              div_zero <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_quo    <= w_abs_a;
              r_dvsr   <= w_abs_b;
              r_r_sign <= a_in[31];
              r_q_sign <= a_in[31] ^ b_in[31];
              r_rem    <= 33'd0;
              r_cnt    <= 6'd0;
              r_state  <= S_RUN;
            end
          end
        end

        S_RUN: begin
          if (r_cnt == C_STEPS) begin
            lo      <= r_q_sign ? (32'd0 - r_quo) : r_quo;
            hi      <= r_r_sign ? (32'd0 - r_rem[31:0]) : r_rem[31:0];
            done    <= 1'b1;
            r_state <= S_DONE;
          end else begin
            if (!w_diff[33]) begin
              r_rem <= w_diff[32:0];
              r_quo <= {r_quo[30:0], 1'b1};
            end else begin
              r_rem <= w_shift[32:0];
              r_quo <= {r_quo[30:0], 1'b0};
            end
            r_cnt <= r_cnt + 6'd1;
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
